// File: rtl/counter_pkg.sv
// Shared encodings for the parameterised counter: mode select and one-shot FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/count_step.sv
// Combinational next-value for one count step: +/-1 with wrap or saturate,
// plus terminal detection for the current direction.
module count_step #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             wrap,
    output logic [WIDTH-1:0] next,
    output logic             at_term,
    output logic             hit
);

    logic [WIDTH-1:0] term;

    always_comb begin
        term    = up_dn ? MAX_VAL : '0;
        at_term = (count == term);
        if (up_dn)
            next = at_term ? (wrap ? '0 : MAX_VAL) : count + 1'b1;
        else
            next = at_term ? (wrap ? MAX_VAL : '0) : count - 1'b1;
        // A wrap away from the terminal never lands on it, so this covers WRAP and SAT alike.
        hit = !at_term && (next == term);
    end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with WRAP, SAT and ONESHOT modes; every output is a flop.
module param_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    mode_e            mode_q;
    state_e           state, state_nxt;
    logic [WIDTH-1:0] count_nxt, step_val, load_clamped;
    logic             tc_nxt, at_term, hit;

    assign mode_q       = mode_e'(mode);
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    count_step #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .count   (count),
        .up_dn   (up_dn),
        .wrap    (mode_q != MODE_SAT),
        .next    (step_val),
        .at_term (at_term),
        .hit     (hit)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = load_clamped;
            state_nxt = ST_IDLE;
        end else if (mode_q == MODE_ONESHOT) begin
            if (start) begin
                // Launching at the terminal finishes immediately.
                if (at_term) begin
                    state_nxt = ST_DONE;
                    tc_nxt    = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end else if (state == ST_RUN && en) begin
                if (at_term) begin
                    state_nxt = ST_DONE;
                    tc_nxt    = 1'b1;
                end else begin
                    count_nxt = step_val;
                    if (hit) begin
                        state_nxt = ST_DONE;
                        tc_nxt    = 1'b1;
                    end
                end
            end
        end else begin
            state_nxt = ST_IDLE;
            if (en) begin
                count_nxt = step_val;
                tc_nxt    = hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tc    <= tc_nxt;
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);
        end
    end

endmodule
